// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs (ALU1, ALU2, MEM) feeding one registered
// common data bus, granted round-robin at one result per cycle.
module cdb_arbiter #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6,
    parameter int ROB_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             alu1_res_valid,
    output logic             alu1_res_ready,
    input  logic [TAG_W-1:0] alu1_res_tag,
    input  logic [31:0]      alu1_res_data,
    input  logic [ROB_W-1:0] alu1_res_rob,
    input  logic             alu1_res_reg_write,

    input  logic             alu2_res_valid,
    output logic             alu2_res_ready,
    input  logic [TAG_W-1:0] alu2_res_tag,
    input  logic [31:0]      alu2_res_data,
    input  logic [ROB_W-1:0] alu2_res_rob,
    input  logic             alu2_res_reg_write,

    input  logic             mem_res_valid,
    output logic             mem_res_ready,
    input  logic [TAG_W-1:0] mem_res_tag,
    input  logic [31:0]      mem_res_data,
    input  logic [ROB_W-1:0] mem_res_rob,
    input  logic             mem_res_reg_write,

    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    output logic [ROB_W-1:0] cdb_rob_num,
    output logic             cdb_reg_write,
    output logic [1:0]       cdb_src
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TAG_W + 32 + ROB_W + 1;

    logic [EW-1:0] mem_q    [3][DEPTH];
    logic [CW-1:0] count_q  [3];
    logic [AW-1:0] rd_ptr_q [3];
    logic [AW-1:0] wr_ptr_q [3];
    logic [1:0]    rr_ptr_q;

    logic [EW-1:0] in_entry [3];
    logic [2:0]    in_valid;
    logic [2:0]    nonempty;
    logic [2:0]    ready;
    logic [2:0]    push;
    logic [2:0]    grant;
    logic [1:0]    winner;
    logic          found;
    logic [2:0]    idx;
    logic [EW-1:0] head_entry;

    assign in_entry[0] = {alu1_res_tag, alu1_res_data, alu1_res_rob, alu1_res_reg_write};
    assign in_entry[1] = {alu2_res_tag, alu2_res_data, alu2_res_rob, alu2_res_reg_write};
    assign in_entry[2] = {mem_res_tag,  mem_res_data,  mem_res_rob,  mem_res_reg_write};
    assign in_valid    = {mem_res_valid, alu2_res_valid, alu1_res_valid};

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            nonempty[i] = (count_q[i] != '0);
            ready[i]    = (count_q[i] < CW'(DEPTH)) || grant[i];
            push[i]     = in_valid[i] && ready[i];
        end
    end

    assign alu1_res_ready = ready[0];
    assign alu2_res_ready = ready[1];
    assign mem_res_ready  = ready[2];

    // Search order starts at rr_ptr and wraps mod 3; first non-empty head wins.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 3'd0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = {1'b0, rr_ptr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && nonempty[idx[1:0]]) begin
                found  = 1'b1;
                winner = idx[1:0];
            end
        end
        grant = found ? (3'b001 << winner) : 3'b000;
    end

    assign head_entry = mem_q[winner][rd_ptr_q[winner]];

    // Storage carries no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (push[i] && !flush) mem_q[i][wr_ptr_q[i]] <= in_entry[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                count_q[i]  <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
            rr_ptr_q <= 2'd0;
        end else if (flush) begin
            for (int unsigned i = 0; i < 3; i++) begin
                count_q[i]  <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
            rr_ptr_q <= 2'd0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                if (grant[i]) rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                case ({push[i], grant[i]})
                    2'b10:   count_q[i] <= count_q[i] + CW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
            if (found) rr_ptr_q <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_data      <= '0;
            cdb_rob_num   <= '0;
            cdb_reg_write <= 1'b0;
            cdb_src       <= 2'd0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (found) begin
            cdb_valid <= 1'b1;
            {cdb_tag, cdb_data, cdb_rob_num, cdb_reg_write} <= head_entry;
            cdb_src   <= winner;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus hand-written
// sequences for saturation fairness and asynchronous reset.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alu1_res_valid, alu2_res_valid, mem_res_valid;
    logic        alu1_res_ready, alu2_res_ready, mem_res_ready;
    logic [5:0]  alu1_res_tag, alu2_res_tag, mem_res_tag;
    logic [31:0] alu1_res_data, alu2_res_data, mem_res_data;
    logic [5:0]  alu1_res_rob, alu2_res_rob, mem_res_rob;
    logic        alu1_res_reg_write, alu2_res_reg_write, mem_res_reg_write;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [5:0]  cdb_rob_num;
    logic        cdb_reg_write;
    logic [1:0]  cdb_src;

    int n_vec  = 0;
    int n_fail = 0;

    cdb_arbiter #(.DEPTH(2), .TAG_W(6), .ROB_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu1_res_valid(alu1_res_valid), .alu1_res_ready(alu1_res_ready),
        .alu1_res_tag(alu1_res_tag), .alu1_res_data(alu1_res_data),
        .alu1_res_rob(alu1_res_rob), .alu1_res_reg_write(alu1_res_reg_write),
        .alu2_res_valid(alu2_res_valid), .alu2_res_ready(alu2_res_ready),
        .alu2_res_tag(alu2_res_tag), .alu2_res_data(alu2_res_data),
        .alu2_res_rob(alu2_res_rob), .alu2_res_reg_write(alu2_res_reg_write),
        .mem_res_valid(mem_res_valid), .mem_res_ready(mem_res_ready),
        .mem_res_tag(mem_res_tag), .mem_res_data(mem_res_data),
        .mem_res_rob(mem_res_rob), .mem_res_reg_write(mem_res_reg_write),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_rob_num(cdb_rob_num), .cdb_reg_write(cdb_reg_write), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    // Payload fields are derived from (source, tag) so a wrong mux select shows up.
    function automatic logic [31:0] data_of(input logic [1:0] s, input logic [5:0] t);
        return {8'hA5, 4'h0, s, 12'h0, t};
    endfunction
    function automatic logic [5:0] rob_of(input logic [5:0] t);
        return t ^ 6'h2A;
    endfunction

    typedef struct {
        logic       flush;
        logic [2:0] v;       // {mem, alu2, alu1}
        logic [5:0] t0, t1, t2;
        logic       ev;
        logic [5:0] et;
        logic [1:0] es;
        logic [2:0] er;      // {mem, alu2, alu1} ready
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic f, input logic [2:0] v,
                                input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                                input logic ev, input logic [5:0] et, input logic [1:0] es,
                                input logic [2:0] er);
        vec_t r;
        r.flush = f; r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2;
        r.ev = ev; r.et = et; r.es = es; r.er = er;
        return r;
    endfunction

    task automatic drive(input logic f, input logic [2:0] v,
                         input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
        flush = f;
        alu1_res_valid = v[0]; alu1_res_tag = t0;
        alu1_res_data = data_of(2'd0, t0); alu1_res_rob = rob_of(t0); alu1_res_reg_write = ^t0;
        alu2_res_valid = v[1]; alu2_res_tag = t1;
        alu2_res_data = data_of(2'd1, t1); alu2_res_rob = rob_of(t1); alu2_res_reg_write = ^t1;
        mem_res_valid  = v[2]; mem_res_tag = t2;
        mem_res_data  = data_of(2'd2, t2); mem_res_rob  = rob_of(t2); mem_res_reg_write  = ^t2;
    endtask

    task automatic check(input string name, input logic ev, input logic [5:0] et,
                         input logic [1:0] es, input logic [2:0] er);
        logic [2:0] rdy;
        logic bad;
        rdy = {mem_res_ready, alu2_res_ready, alu1_res_ready};
        n_vec++;
        bad = (cdb_valid !== ev) || (rdy !== er);
        if (ev && !bad)
            bad = (cdb_tag !== et) || (cdb_src !== es) || (cdb_data !== data_of(es, et)) ||
                  (cdb_rob_num !== rob_of(et)) || (cdb_reg_write !== ^et);
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got valid=%b tag=%0d src=%0d data=%h rob=%0d rw=%b ready=%b; want valid=%b tag=%0d src=%0d data=%h rob=%0d rw=%b ready=%b",
                     name, cdb_valid, cdb_tag, cdb_src, cdb_data, cdb_rob_num, cdb_reg_write, rdy,
                     ev, et, es, data_of(es, et), rob_of(et), ^et, er);
        end
    endtask

    task automatic check_zero(input string name);
        logic [2:0] rdy;
        rdy = {mem_res_ready, alu2_res_ready, alu1_res_ready};
        n_vec++;
        if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || cdb_rob_num !== '0 ||
            cdb_reg_write !== 1'b0 || cdb_src !== 2'd0 || rdy !== 3'b111) begin
            n_fail++;
            $display("FAIL %s: got valid=%b tag=%0d data=%h rob=%0d rw=%b src=%0d ready=%b; want all zero, ready=111",
                     name, cdb_valid, cdb_tag, cdb_data, cdb_rob_num, cdb_reg_write, cdb_src, rdy);
        end
    endtask

    logic [5:0] q0[$], q1[$], q2[$];
    logic [5:0] head;
    logic [3:0] cnt [3];
    int         grants [3];
    logic [2:0] rdy_pre;

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;

        //        flush  v      t0     t1     t2     ev    et     es    ready
        tbl.push_back(mk(0, 3'b001, 6'd5,  6'd0,  6'd0,  0, 6'd0,  2'd0, 3'b111)); // single: no bypass
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd5,  2'd0, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  2'd0, 3'b111));
        tbl.push_back(mk(1, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  2'd0, 3'b111)); // rr back to 0
        tbl.push_back(mk(0, 3'b111, 6'd1,  6'd2,  6'd3,  0, 6'd0,  2'd0, 3'b111)); // collision
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd1,  2'd0, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd2,  2'd1, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd3,  2'd2, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  2'd0, 3'b111));
        tbl.push_back(mk(0, 3'b010, 6'd0,  6'd10, 6'd0,  0, 6'd0,  2'd0, 3'b111)); // ALU2 streams alone
        tbl.push_back(mk(0, 3'b010, 6'd0,  6'd11, 6'd0,  1, 6'd10, 2'd1, 3'b111));
        tbl.push_back(mk(0, 3'b010, 6'd0,  6'd12, 6'd0,  1, 6'd11, 2'd1, 3'b111));
        tbl.push_back(mk(0, 3'b111, 6'd20, 6'd13, 6'd30, 1, 6'd12, 2'd1, 3'b111)); // saturation
        tbl.push_back(mk(0, 3'b111, 6'd21, 6'd14, 6'd31, 1, 6'd30, 2'd2, 3'b101));
        tbl.push_back(mk(0, 3'b111, 6'd22, 6'd15, 6'd32, 1, 6'd20, 2'd0, 3'b010));
        tbl.push_back(mk(0, 3'b111, 6'd23, 6'd15, 6'd33, 1, 6'd13, 2'd1, 3'b100));
        tbl.push_back(mk(0, 3'b111, 6'd23, 6'd16, 6'd33, 1, 6'd31, 2'd2, 3'b001));
        tbl.push_back(mk(0, 3'b111, 6'd23, 6'd16, 6'd34, 1, 6'd21, 2'd0, 3'b010));
        tbl.push_back(mk(1, 3'b111, 6'd24, 6'd16, 6'd34, 0, 6'd0,  2'd0, 3'b111)); // flush while full, rr=1
        tbl.push_back(mk(0, 3'b011, 6'd41, 6'd40, 6'd0,  0, 6'd0,  2'd0, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd41, 2'd0, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd40, 2'd1, 3'b111));
        tbl.push_back(mk(0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  2'd0, 3'b111));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].flush, tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].t2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].et, tbl[i].es, tbl[i].er);
        end

        // Fairness under saturation, starting from a flushed arbiter.
        drive(1'b1, 3'b000, 6'd0, 6'd0, 6'd0);
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin cnt[s] = 4'd0; grants[s] = 0; end
        for (int cyc = 0; cyc <= 30; cyc++) begin
            drive(1'b0, 3'b111, {2'd0, cnt[0]}, {2'd1, cnt[1]}, {2'd2, cnt[2]});
            rdy_pre = {mem_res_ready, alu2_res_ready, alu1_res_ready};
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                check("fair_fill", 1'b0, 6'd0, 2'd0, 3'b111);
            end else begin
                head = 6'd0;
                case ((cyc - 1) % 3)
                    0: if (q0.size() > 0) head = q0.pop_front();
                    1: if (q1.size() > 0) head = q1.pop_front();
                    default: if (q2.size() > 0) head = q2.pop_front();
                endcase
                check($sformatf("fair%0d", cyc), 1'b1, head, 2'((cyc - 1) % 3),
                      {mem_res_ready, alu2_res_ready, alu1_res_ready});
                if (cdb_valid && cdb_src < 2'd3) grants[cdb_src]++;
            end
            if (rdy_pre[0]) begin q0.push_back({2'd0, cnt[0]}); cnt[0]++; end
            if (rdy_pre[1]) begin q1.push_back({2'd1, cnt[1]}); cnt[1]++; end
            if (rdy_pre[2]) begin q2.push_back({2'd2, cnt[2]}); cnt[2]++; end
        end
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (grants[s] != 10) begin
                n_fail++;
                $display("FAIL fair_count src%0d: got %0d grants, want 10", s, grants[s]);
            end
        end

        // Asynchronous reset between edges while the CDB is busy.
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        drive(1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d", i), 1'b0, 6'd0, 2'd0, 3'b111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) among the three issue-side functional units: ALU1, ALU2 and MEM. It sits between the unit writeback ports and the CDB broadcast that the issue queue, ROB and register file snoop. Each source has a small result FIFO with a valid/ready handshake. One result per cycle is granted round-robin and driven onto registered CDB outputs.

## Interface
Parameters
- DEPTH, 2: result FIFO entries per source (power of two, ≥2).
- TAG_W, 6: physical register tag width.
- ROB_W, 6: ROB index width.

Ports. One clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous; drop all buffered results and the CDB output this cycle.
- alu1_res_valid / alu2_res_valid / mem_res_valid  in  1  source result valid.
- alu1_res_ready / alu2_res_ready / mem_res_ready  out  1  source may push this cycle.
- {alu1,alu2,mem}_res_tag  in  TAG_W  destination physical register.
- {alu1,alu2,mem}_res_data  in  32  result value.
- {alu1,alu2,mem}_res_rob  in  ROB_W  ROB entry to complete.
- {alu1,alu2,mem}_res_reg_write  in  1  result writes a register (0 = store).
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W.
- cdb_data  out  32.
- cdb_rob_num  out  ROB_W.
- cdb_reg_write  out  1.
- cdb_src  out  2  source index: 0 = ALU1, 1 = ALU2, 2 = MEM.

## Operation
- Push: the entry {tag, data, rob, reg_write} is written into source i's FIFO at the clock edge when res_valid_i && res_ready_i.
- Ready: res_ready_i = (count_i < DEPTH) || grant_i. A full FIFO therefore accepts a push in the same cycle its head is granted. Ready never depends on res_valid.
- Arbitration is combinational over the non-empty FIFO heads.
  - rr_ptr ∈ {0,1,2}. The search starts at rr_ptr and proceeds in increasing index order, mod 3.
  - At most one grant per cycle.
- On a grant at an edge:
  - Pop the winner's head.
  - Register the head onto the cdb_* outputs with cdb_valid=1 and cdb_src=winner.
  - Set rr_ptr = (winner+1) mod 3.
- No grant: cdb_valid=0 next cycle and rr_ptr holds. The cdb_tag/data/rob/reg_write/src outputs hold their last values; consumers must ignore them when cdb_valid=0.
- The CDB has no backpressure; every cdb_valid cycle is consumed.
- Counts are $clog2(DEPTH)+1 bits. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop on the same FIFO leaves the count unchanged. Order within a source is strictly FIFO.
- flush=1 at an edge has priority over push and grant:
  - All counts and pointers go to 0 and cdb_valid goes to 0.
  - rr_ptr resets to 0.
  - Pushes in that cycle are discarded. Ready is still computed normally; sources must not rely on it during a flush.
- Reset values: all FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_rob_num=0, cdb_reg_write=0, cdb_src=0. res_ready_* = 1 after reset.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge. Buffered results are lost.

## Timing
- Latency: a result pushed at edge N appears on the CDB no earlier than after edge N+1. This holds even into an empty arbiter (no bypass).
- Sustained throughput: 1 result/cycle total. Under saturation each source gets exactly 1 grant per 3 cycles.
- Worst-case wait for a non-empty head: 2 cycles after it becomes head.
- A single source streaming alone, with valid held high, sees ready stay at 1 and gets back-to-back CDB slots after the 1-cycle fill.

## Test plan
- **Single result.** After reset, ALU1 pushes tag=5, data=0xDEADBEEF, rob=3, reg_write=1 at edge 1.
  - Required: cdb_valid=1 with exactly those values and cdb_src=0 after edge 2 only; cdb_valid=0 after edge 3.
- **Three-way collision.** All three sources push at edge 1 (tags 1, 2, 3).
  - Required: the CDB carries tag 1 (src 0), then tag 2 (src 1), then tag 3 (src 2) after edges 2, 3 and 4.
- **Round-robin fairness.** All sources continuously valid for 30 cycles.
  - Required: grant order repeats 0,1,2 with exactly 10 grants each, and no cdb_valid gaps after the first cycle.
- **Backpressure.** ALU2 alone pushes every cycle, then MEM and ALU1 saturate so that ALU2 is granted 1 in 3 cycles.
  - Required: alu2_res_ready drops only when count=DEPTH with no grant.
  - Required: no result is lost or reordered; the ALU2 tag sequence on the CDB equals the pushed sequence.
- **Flush.** Fill all FIFOs to DEPTH, then assert flush for one cycle.
  - Required: cdb_valid=0 the next cycle.
  - Required: all readies are 1 and rr_ptr restarts at ALU1, i.e. a new ALU2 push followed by an ALU1 push sees ALU1's entry granted first when both are pending.
- **Asynchronous reset mid-stream.** Assert rst between edges while the CDB is busy.
  - Required: cdb_valid and all cdb_* outputs read 0 before the next edge; no pre-reset result appears after reset deasserts.
